serial_adder: RTL
=================

# serial_adder

Bit-serial adder that sequences the one-bit full adder across a WIDTH-bit operand pair, LSB first, with a registered carry between bits. It sits directly upstream of the full-adder stage: it feeds one bit of each operand plus the stored carry per cycle and collects the sum bit and carry-out. It produces a WIDTH-bit sum and final carry behind valid/ready handshakes on both sides. Area-for-latency alternative to a ripple-carry chain.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range ≥ 2.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- carry_in  input  1  initial carry, sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  downstream consumes the result.
- out_sum  output  WIDTH  (a + b + carry_in) mod 2^WIDTH.
- out_carry  output  1  bit WIDTH of a + b + carry_in.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - load a_sr←a, b_sr←b, carry_r←carry_in, cnt←0.
  - Go to RUN.
- RUN: each cycle the full adder computes on a_sr[0], b_sr[0], carry_r.
  - Sum bit shifts into sum_sr MSB; sum_sr, a_sr and b_sr shift right by one.
  - carry_r←bit carry-out; cnt←cnt+1.
  - On the edge where cnt==WIDTH-1: copy the completed sum (including this bit) to out_sum and the final carry to out_carry, then go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. a, b and carry_in are ignored outside the accept edge.
- out_sum and out_carry are output registers. They change only on the RUN→DONE edge and hold the last result otherwise, including after the handshake.
- Arithmetic: cnt is $clog2(WIDTH) bits wide. No overflow flag; out_carry is the only overflow indication.
- Reset, at any time including mid-RUN:
  - state←IDLE; all shift registers, cnt, carry_r, out_sum and out_carry←0; out_valid←0.
  - The in-flight operation is discarded.
  - in_ready=1 on the first cycle after rst_n deasserts.

## Timing
- Accept on edge E0. Bit i is computed at edge E(i+1).
- out_valid rises after edge E_WIDTH, i.e. WIDTH cycles after the accept edge.
- Earliest result handshake is at E(WIDTH+1); earliest next accept is at E(WIDTH+2).
- Maximum throughput is one operation per WIDTH+2 cycles.
- out_valid is held, with out_sum and out_carry stable, for as long as out_ready is low. No timeout.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- An out_ready that is high when out_valid is low has no effect.

## Structure
- Shared package serial_adder_pkg holds:
  - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - default WIDTH;
  - the counter-width function/constant.
- One sub-module, full_adder_bit: combinational one-bit full adder built from two half-adder instances.
  - Carry-out is the OR of both half-adder carries.
  - Instantiated once in the datapath.
- Remaining logic (FSM, shift registers, counter, output registers) lives in serial_adder.

## Test plan
- Reset: assert rst_n=0 mid-simulation, then release → all outputs 0, in_ready=1 on the first cycle after release, out_valid=0.
- WIDTH=8, a=8'h5A, b=8'h3C, carry_in=0 → out_sum=8'h96, out_carry=0, out_valid high exactly 8 cycles after the accept edge.
- Carry edges:
  - a=8'hFF, b=8'h01, carry_in=0 → 8'h00, carry 1.
  - a=8'hFF, b=8'hFF, carry_in=1 → 8'hFF, carry 1.
  - a=8'h00, b=8'h00, carry_in=1 → 8'h01, carry 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with different a/b → out_sum stable, in_ready=0, new operands not accepted until after the result handshake.
- Reset mid-RUN after bit 3 → IDLE immediately, no out_valid pulse. The next operation (a=8'h12, b=8'h34, carry_in=0) → 8'h46, carry 0.
- Streaming: 1000 random operations with out_ready always high, repeated at WIDTH=2 and WIDTH=16 → every result matches a + b + carry_in and the accept-to-accept period is WIDTH+2.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit counter width; clamped to 1 so a degenerate width still elaborates.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder assembled from two half adders; purely combinational.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  logic partial_sum;
  logic carry_ab;
  logic carry_pc;

  half_adder u_ha_ab (
    .a     (a),
    .b     (b),
    .sum   (partial_sum),
    .carry (carry_ab)
  );

  half_adder u_ha_pc (
    .a     (partial_sum),
    .b     (carry_in),
    .sum   (sum),
    .carry (carry_pc)
  );

  // Both carries can never be high together, so OR is exact.
  assign carry_out = carry_ab | carry_pc;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: walks one full adder across WIDTH bits LSB first,
// with valid/ready handshakes on operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_r;
  logic [CNT_W-1:0] cnt;
  logic             sum_bit;
  logic             carry_bit;

  full_adder_bit u_fa (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .carry_in  (carry_r),
    .sum       (sum_bit),
    .carry_out (carry_bit)
  );

  // in_ready/out_valid are kept as flops so neither depends on the handshake inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_r   <= 1'b0;
      cnt       <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            carry_r  <= carry_in;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr  <= {sum_bit, sum_sr[WIDTH-1:1]};
          carry_r <= carry_bit;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            out_sum   <= {sum_bit, sum_sr[WIDTH-1:1]};
            out_carry <= carry_bit;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
